// File: rtl/matvec_pkg.sv
// Shared types and defaults for the matrix-vector product sequencer.
package matvec_pkg;

  localparam int N_DEF  = 32;
  localparam int DW_DEF = 32;
  localparam int FRAC   = 21;

  // Q11.21 signed fixed point: bit 10 is the sign, bit -21 the LSB.
  typedef logic signed [10:-21] q11_21_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_OUT   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/matvec_sched_if.sv
// Operand-memory, accumulator and result handshake bundle of the sequencer.
interface matvec_sched_if import matvec_pkg::*; #(
  parameter int AW = 5,
  parameter int DW = DW_DEF
);

  logic            rd_en;
  logic [2*AW-1:0] mat_addr;
  logic [AW-1:0]   vec_addr;
  logic            acc_ena;
  logic            acc_clr;
  logic [DW-1:0]   acc_in;
  logic            res_valid;
  logic            res_ready;
  logic [DW-1:0]   res_data;
  logic [AW-1:0]   res_row;

  modport master (
    output rd_en, mat_addr, vec_addr, acc_ena, acc_clr,
    output res_valid, res_data, res_row,
    input  acc_in, res_ready
  );

  modport slave (
    input  rd_en, mat_addr, vec_addr, acc_ena, acc_clr,
    input  res_valid, res_data, res_row,
    output acc_in, res_ready
  );

endinterface

// File: rtl/lat_pipe.sv
// LAT-deep single-bit delay line with a synchronous flush of every stage.
module lat_pipe #(
  parameter int LAT = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_flush,
  input  logic i_d,
  output logic o_q
);

  logic [LAT-1:0] r_sh;

  // shift the strobe toward the output; flush empties the whole line at once
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) r_sh <= '0;
    else                  r_sh <= (r_sh << 1) | LAT'(i_d);
  end

  assign o_q = r_sh[LAT-1];

endmodule

// File: rtl/matvec_sched.sv
// Row sequencer for the NxN matrix-vector product: reads, accumulate control,
// drain of the read/accumulate latency and valid/ready result hand-off.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one read per cycle, col 0..N-1 of the current row
// DRAIN | LAT+1 cycles for the last product to land in acc_in
// OUT   | result presented, waiting for res_ready
// DONE  | one-cycle done pulse after the last row
module matvec_sched import matvec_pkg::*; #(
  parameter int N   = N_DEF,
  parameter int AW  = $clog2(N),
  parameter int DW  = DW_DEF,
  parameter int LAT = 1
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic           i_abort,
  output logic           o_busy,
  output logic           o_done,
  matvec_sched_if.master bus
);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_RUN   = ST_RUN;
  localparam logic [2:0] S_DRAIN = ST_DRAIN;
  localparam logic [2:0] S_OUT   = ST_OUT;
  localparam logic [2:0] S_DONE  = ST_DONE;
  localparam logic [2:0] LAT_CNT = 3'(LAT);

  logic [2:0]    r_state;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic [2:0]    r_drain;
  logic [DW-1:0] r_res_data;
  logic [AW-1:0] r_res_row;

  logic [2:0] w_next;
  logic       w_idle;
  logic       w_go;
  logic       w_abort;
  logic       w_hs;
  logic       w_last_col;
  logic       w_last_row;
  logic       w_drain_tc;
  logic       w_rd_en;

  assign w_idle     = (r_state == S_IDLE);
  assign w_go       = w_idle && i_start;
  // abort is meaningless in IDLE, so start always wins there
  assign w_abort    = i_abort && !w_idle;
  assign w_hs       = (r_state == S_OUT) && bus.res_ready;
  assign w_last_col = (r_col == AW'(N-1));
  assign w_last_row = (r_row == AW'(N-1));
  assign w_drain_tc = (r_drain == 3'd0);
  assign w_rd_en    = (r_state == S_RUN);

  // next-state decode; abort overrides every transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start)    w_next = S_RUN;
      S_RUN:   if (w_last_col) w_next = S_DRAIN;
      S_DRAIN: if (w_drain_tc) w_next = S_OUT;
      S_OUT:   if (w_hs)       w_next = w_last_row ? S_DONE : S_RUN;
      S_DONE:                  w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  // state, row/col indices, drain down-counter and result capture
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_row      <= '0;
      r_col      <= '0;
      r_drain    <= '0;
      r_res_data <= '0;
      r_res_row  <= '0;
    end else begin
      r_state <= w_next;
      if (w_abort || w_go || r_state == S_DONE) begin
        r_row   <= '0;
        r_col   <= '0;
        r_drain <= '0;
      end else begin
        if (r_state == S_RUN) begin
          r_col <= w_last_col ? '0 : r_col + 1'b1;
          if (w_last_col) r_drain <= LAT_CNT;
        end
        if (r_state == S_DRAIN) begin
          if (w_drain_tc) begin
            r_res_data <= bus.acc_in;
            r_res_row  <= r_row;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        if (w_hs && !w_last_row) r_row <= r_row + 1'b1;
      end
    end
  end

  lat_pipe #(.LAT(LAT)) u_ena_pipe (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_abort),
    .i_d     (w_rd_en),
    .o_q     (bus.acc_ena)
  );

  assign o_busy        = !w_idle;
  assign o_done        = (r_state == S_DONE);
  assign bus.rd_en     = w_rd_en;
  assign bus.mat_addr  = {r_row, r_col};
  assign bus.vec_addr  = r_col;
  // clear on entry, on every hand-off and on abort so no partial sum survives
  assign bus.acc_clr   = !i_rst && (w_go || w_hs || w_abort);
  assign bus.res_valid = (r_state == S_OUT);
  assign bus.res_data  = r_res_data;
  assign bus.res_row   = r_res_row;

endmodule

// File: tb/tb_matvec_sched.sv
// Directed bench for matvec_sched with a memory + accumulator model.
module tb_matvec_sched;
  import matvec_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic tb_rst, tb_start, tb_abort, tb_ready, tb_start3;
  logic w_busy, w_done, w_busy3, w_done3;

  matvec_sched_if #(.AW(5), .DW(32)) u_if ();
  matvec_sched_if #(.AW(5), .DW(32)) u_if3 ();

  matvec_sched #(.N(32), .AW(5), .DW(32), .LAT(1)) u_dut (
    .i_clk(clk), .i_rst(tb_rst), .i_start(tb_start), .i_abort(tb_abort),
    .o_busy(w_busy), .o_done(w_done), .bus(u_if.master));

  matvec_sched #(.N(32), .AW(5), .DW(32), .LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst(tb_rst), .i_start(tb_start3), .i_abort(1'b0),
    .o_busy(w_busy3), .o_done(w_done3), .bus(u_if3.master));

  // memory and accumulator model for the LAT=1 instance
  logic [31:0] mat [1024];
  logic [31:0] vec [32];
  logic [31:0] rd_m, rd_v, acc, cnt3;

  function automatic logic [31:0] qmul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return 32'(p >>> FRAC);
  endfunction

  always @(posedge clk) begin
    if (u_if.rd_en) begin
      rd_m <= mat[u_if.mat_addr];
      rd_v <= vec[u_if.vec_addr];
    end
    if (u_if.acc_clr)      acc <= '0;
    else if (u_if.acc_ena) acc <= acc + qmul(rd_m, rd_v);
    if (u_if3.acc_clr)      cnt3 <= '0;
    else if (u_if3.acc_ena) cnt3 <= cnt3 + 32'd1;
  end

  assign u_if.acc_in     = acc;
  assign u_if.res_ready  = tb_ready;
  assign u_if3.acc_in    = cnt3;
  assign u_if3.res_ready = 1'b1;

  int n_chk, n_fail;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] outs1();
    return 64'({w_busy, w_done, u_if.rd_en, u_if.mat_addr, u_if.vec_addr, u_if.acc_ena,
                u_if.acc_clr, u_if.res_valid, u_if.res_data, u_if.res_row});
  endfunction

  function automatic logic [63:0] outs3();
    return 64'({w_busy3, w_done3, u_if3.rd_en, u_if3.mat_addr, u_if3.vec_addr, u_if3.acc_ena,
                u_if3.acc_clr, u_if3.res_valid, u_if3.res_data, u_if3.res_row});
  endfunction

  // per-job observations
  int          n_hs, done_cyc, n_rd, n_ena, n_clr, stall_bad, abort_cyc, post_hs_rd, clr_bad;
  int          hs_cyc [32];
  logic [31:0] hs_data [32];
  logic [4:0]  hs_row [32];
  int          ena_row [33];

  task automatic run_job(input int stall_row, input int abort_at, input bit glitch, input int budget);
    int rel, stall_n;
    logic [31:0] held_d;
    logic [4:0]  held_r;
    bit aborted, fin, timed_out;
    n_hs = 0; done_cyc = -1; n_rd = 0; n_ena = 0; n_clr = 0; stall_bad = 0;
    abort_cyc = -1; post_hs_rd = -1; clr_bad = 0;
    for (int r = 0; r < 33; r++) ena_row[r] = 0;
    stall_n = 0; aborted = 0; fin = 0; timed_out = 0; rel = 0;
    held_d = '0; held_r = '0;
    tick();
    tb_start = 1; tb_ready = 1; tb_abort = 0;
    while (!fin) begin
      @(negedge clk);
      if (rel == 0) begin
        chk("start_clr", u_if.acc_clr, 1);
        chk("start_busy", w_busy, 0);
      end
      if (rel == 1) begin
        chk("run_rd", u_if.rd_en, 1);
        chk("run_addr0", u_if.mat_addr, 0);
      end
      if (u_if.rd_en) n_rd++;
      if (u_if.rd_en && n_hs == stall_row + 1 && post_hs_rd < 0) post_hs_rd = rel;
      if (u_if.acc_ena) begin
        n_ena++;
        if (n_hs < 33) ena_row[n_hs]++;
      end
      if (u_if.acc_clr) n_clr++;
      if (u_if.res_valid && !tb_ready) begin
        if (stall_n == 1 && held_d == '0 && held_r == '0) begin
          held_d = u_if.res_data; held_r = u_if.res_row;
        end else if (u_if.res_data != held_d || u_if.res_row != held_r) stall_bad++;
        if (u_if.rd_en || u_if.acc_ena) stall_bad++;
      end
      if (u_if.res_valid && tb_ready) begin
        if (n_hs < 32) begin
          hs_cyc[n_hs] = rel; hs_data[n_hs] = u_if.res_data; hs_row[n_hs] = u_if.res_row;
        end
        if (!u_if.acc_clr) clr_bad++;
        n_hs++;
      end
      if (aborted && rel == abort_cyc) chk("abort_clr", u_if.acc_clr, 1);
      if (aborted && rel == abort_cyc + 1) begin
        chk("abort_busy", w_busy, 0);
        chk("abort_rd", u_if.rd_en, 0);
        chk("abort_ena", u_if.acc_ena, 0);
        chk("abort_valid", u_if.res_valid, 0);
        chk("abort_done", w_done, 0);
        fin = 1;
      end
      if (w_done) begin done_cyc = rel; fin = 1; end
      if (rel >= budget) begin timed_out = 1; fin = 1; end
      if (!fin) begin
        tick();
        rel++;
        tb_start = 0; tb_abort = 0; tb_ready = 1;
        if (u_if.res_valid && u_if.res_row == stall_row && stall_n < 10) begin
          tb_ready = 0; stall_n++;
        end
        if (abort_at >= 0 && !aborted && u_if.rd_en && u_if.mat_addr == abort_at) begin
          tb_abort = 1; aborted = 1; abort_cyc = rel;
        end
        if (glitch && ((u_if.rd_en && u_if.vec_addr == 5'd7) || u_if.res_valid)) tb_start = 1;
      end
    end
    chk("job_timeout", timed_out, 0);
    tick();
    tb_start = 0; tb_abort = 0; tb_ready = 1;
  endtask

  int quiet, rel3, first_rd3, first_ena3, n_hs3, done3, n_ena3;
  int hs3_cyc [2];
  logic [31:0] hs3_data [2];
  bit fin3, to3;

  initial begin
    n_chk = 0; n_fail = 0;
    tb_rst = 1; tb_start = 0; tb_abort = 0; tb_ready = 1; tb_start3 = 0;
    for (int i = 0; i < 1024; i++) mat[i] = ((i >> 5) == (i & 31)) ? 32'h0020_0000 : 32'h0;
    for (int k = 0; k < 32; k++) vec[k] = 32'(k) << 21;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_outs", outs1(), 0);
    chk("rst_outs3", outs3(), 0);
    tick();
    tb_rst = 0;
    @(negedge clk);
    chk("idle_outs", outs1(), 0);

    // identity matrix, v[k] = k
    run_job(-1, -1, 0, 2000);
    chk("id_n_hs", n_hs, 32);
    chk("id_done", done_cyc, 1121);
    chk("id_n_rd", n_rd, 1024);
    chk("id_n_ena", n_ena, 1024);
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("id_cyc[%0d]", r), hs_cyc[r], 35 * (r + 1));
      chk($sformatf("id_row[%0d]", r), hs_row[r], r);
      chk($sformatf("id_data[%0d]", r), hs_data[r], 32'(r) << 21);
    end

    // consumer stalls row 3 for 10 cycles
    run_job(3, -1, 0, 2000);
    chk("st_n_hs", n_hs, 32);
    chk("st_hs2", hs_cyc[2], 105);
    chk("st_hs3", hs_cyc[3], 150);
    chk("st_hs4", hs_cyc[4], 185);
    chk("st_row4_rd", post_hs_rd, 151);
    chk("st_stable", stall_bad, 0);
    chk("st_data3", hs_data[3], 32'h0060_0000);
    chk("st_row3", hs_row[3], 3);
    chk("st_done", done_cyc, 1131);
    chk("st_n_rd", n_rd, 1024);

    // start pulsed during RUN and OUT is ignored
    run_job(-1, -1, 1, 2000);
    chk("gl_n_hs", n_hs, 32);
    chk("gl_done", done_cyc, 1121);
    chk("gl_n_rd", n_rd, 1024);
    chk("gl_hs31", hs_cyc[31], 1120);
    chk("gl_data31", hs_data[31], 32'h03E0_0000);

    // all-ones matrix, vector of 1.0
    for (int i = 0; i < 1024; i++) mat[i] = 32'h0020_0000;
    for (int k = 0; k < 32; k++) vec[k] = 32'h0020_0000;
    run_job(-1, -1, 0, 2000);
    chk("one_n_hs", n_hs, 32);
    chk("one_done", done_cyc, 1121);
    chk("one_n_clr", n_clr, 33);
    chk("one_clr_hs", clr_bad, 0);
    for (int r = 0; r < 32; r++) begin
      chk($sformatf("one_data[%0d]", r), hs_data[r], 32'h0400_0000);
      chk($sformatf("one_ena[%0d]", r), ena_row[r], 32);
    end

    // abort in row 5 at col 12
    run_job(-1, 5 * 32 + 12, 0, 2000);
    chk("ab_cyc", abort_cyc, 188);
    chk("ab_n_hs", n_hs, 5);
    chk("ab_data4", hs_data[4], 32'h0400_0000);
    chk("ab_no_done", done_cyc, -1);
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_done || u_if.res_valid || w_busy || u_if.rd_en || u_if.acc_ena) quiet++;
      tick();
    end
    chk("ab_quiet", quiet, 0);

    // fresh job after abort
    run_job(-1, -1, 0, 2000);
    chk("pa_n_hs", n_hs, 32);
    chk("pa_cyc0", hs_cyc[0], 35);
    chk("pa_row0", hs_row[0], 0);
    chk("pa_data0", hs_data[0], 32'h0400_0000);
    chk("pa_done", done_cyc, 1121);

    // reset in the middle of row 0 DRAIN
    tick();
    tb_start = 1;
    for (int k = 1; k <= 33; k++) begin
      tick();
      tb_start = 0;
    end
    @(negedge clk);
    chk("pre_rst_busy", w_busy, 1);
    chk("pre_rst_rd", u_if.rd_en, 0);
    tb_rst = 1;
    tick();
    @(negedge clk);
    chk("drain_rst_outs", outs1(), 0);
    tick();
    tb_rst = 0;
    quiet = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_done || u_if.res_valid || w_busy) quiet++;
      tick();
    end
    chk("post_rst_quiet", quiet, 0);

    // LAT=3 instance: acc_ena lag and 37-cycle row period
    tick();
    tb_start3 = 1;
    rel3 = 0; first_rd3 = -1; first_ena3 = -1; n_hs3 = 0; done3 = -1; n_ena3 = 0;
    fin3 = 0; to3 = 0;
    hs3_cyc[0] = -1; hs3_cyc[1] = -1; hs3_data[0] = '0; hs3_data[1] = '0;
    while (!fin3) begin
      @(negedge clk);
      if (u_if3.rd_en && first_rd3 < 0) first_rd3 = rel3;
      if (u_if3.acc_ena) begin
        n_ena3++;
        if (first_ena3 < 0) first_ena3 = rel3;
      end
      if (u_if3.res_valid) begin
        if (n_hs3 < 2) begin
          hs3_cyc[n_hs3] = rel3; hs3_data[n_hs3] = u_if3.res_data;
        end
        n_hs3++;
      end
      if (w_done3) begin done3 = rel3; fin3 = 1; end
      if (rel3 >= 3000) begin to3 = 1; fin3 = 1; end
      if (!fin3) begin
        tick();
        rel3++;
        tb_start3 = 0;
      end
    end
    tb_start3 = 0;
    chk("l3_timeout", to3, 0);
    chk("l3_first_rd", first_rd3, 1);
    chk("l3_first_ena", first_ena3, 4);
    chk("l3_hs0", hs3_cyc[0], 37);
    chk("l3_hs1", hs3_cyc[1], 74);
    chk("l3_data0", hs3_data[0], 32);
    chk("l3_data1", hs3_data[1], 32);
    chk("l3_n_hs", n_hs3, 32);
    chk("l3_n_ena", n_ena3, 1024);
    chk("l3_done", done3, 1185);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
